// File: rtl/eeprom_pkg.sv
// Shared constants and types for the SPI EEPROM page-write sequencer.
package eeprom_pkg;

  // 25xx-style opcodes
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;

  // Steps per page frame: WREN, WRITE, addr hi, addr lo, then 256 data bytes
  localparam logic [8:0] STEP_LAST = 9'd259;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4
  } state_t;

endpackage

// File: rtl/write_eeprom.sv
// Byte-level sequencer feeding an SPI byte transmitter to write 256-byte
// pages into an SPI EEPROM. One start_pulse sends one byte of the sequence.
module write_eeprom
  import eeprom_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned PAGE_BYTES = 256,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pulse,
  input  logic       spi_busy,
  output logic       load_data,
  output logic       nCS,
  output logic [7:0] dataout
);

  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  state_t              r_state;
  logic [8:0]          r_step;
  logic [ADDR_W-1:0]   r_page_addr;
  logic [GAP_W-1:0]    r_gap;
  logic                r_busy_seen;
  logic                r_load;
  logic                r_ncs;
  logic [7:0]          r_dataout;
  logic [7:0]          w_byte;
  logic                w_frame_end;

  // Byte belonging to the current step of the page sequence
  always_comb begin
    w_byte = '0;
    case (r_step)
      9'd0:    w_byte = OP_WREN;
      9'd1:    w_byte = OP_WRITE;
      9'd2:    w_byte = r_page_addr[ADDR_W-1 -: 8];
      9'd3:    w_byte = r_page_addr[7:0];
      // data index is (step - 4) mod 256; low byte arithmetic is sufficient
      default: w_byte = r_step[7:0] - 8'd4;
    endcase
  end

  // WREN is its own frame; the last data byte closes the WRITE frame
  always_comb begin
    w_frame_end = (r_step == 9'd0) || (r_step == STEP_LAST);
  end

  // Sequencer FSM with step counter, page address and chip-select timing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_page_addr <= '0;
      r_gap       <= '0;
      r_busy_seen <= 1'b0;
      r_load      <= 1'b0;
      r_ncs       <= 1'b1;
      r_dataout   <= '0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_pulse) begin
            r_ncs     <= 1'b0;
            r_dataout <= w_byte;
            r_load    <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          // busy seen during the strobe cycle still satisfies WAIT_HI
          r_busy_seen <= spi_busy;
          r_state     <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (spi_busy || r_busy_seen) begin
            r_busy_seen <= 1'b0;
            r_state     <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!spi_busy) begin
            if (r_step == STEP_LAST) begin
              r_step      <= '0;
              r_page_addr <= r_page_addr + ADDR_W'(PAGE_BYTES);
            end else begin
              r_step <= r_step + 9'd1;
            end
            if (w_frame_end) begin
              r_ncs   <= 1'b1;
              r_gap   <= '0;
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_W'(CS_GAP - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_data = r_load;
  assign nCS       = r_ncs;
  assign dataout   = r_dataout;

endmodule

// File: tb/tb_write_eeprom.sv
// Self-checking bench for write_eeprom: randomized handshake timing checked
// against a step/page-address model of the page-write byte sequence.
module tb_write_eeprom;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_pulse;
  logic       spi_busy;
  logic       load_data;
  logic       nCS;
  logic [7:0] dataout;

  int checks = 0;
  int errors = 0;

  // reference model: position in the page sequence and page base address
  int m_step = 0;
  int m_page = 0;

  write_eeprom #(.ADDR_W(16), .PAGE_BYTES(256), .CS_GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_pulse(start_pulse),
    .spi_busy   (spi_busy),
    .load_data  (load_data),
    .nCS        (nCS),
    .dataout    (dataout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_byte(input int step, input int page);
    if (step == 0) return 8'h06;
    if (step == 1) return 8'h02;
    if (step == 2) return 8'((page / 256) % 256);
    if (step == 3) return 8'(page % 256);
    return 8'((step - 4) % 256);
  endfunction

  task automatic model_next(output logic [7:0] eb, output logic ecs);
    eb  = model_byte(m_step, m_page);
    ecs = (m_step == 0 || m_step == 259);
    if (m_step == 259) begin
      m_step = 0;
      m_page = (m_page + 256) % 65536;
    end else begin
      m_step = m_step + 1;
    end
  endtask

  // Drives one start + busy handshake and records what the DUT showed.
  task automatic do_byte(input int delay, input int len, input bit inject,
                         output logic [7:0] d, output int load_cnt,
                         output bit load_first, output bit stable,
                         output bit ncs_low, output logic ncs_after,
                         output bit tail_ok);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    load_first = (load_data === 1'b1);
    load_cnt   = load_first ? 1 : 0;
    d          = dataout;
    ncs_low    = (nCS === 1'b0);
    stable     = 1'b1;
    tail_ok    = 1'b1;
    for (int i = 0; i < delay; i++) begin
      tick();
      start_pulse = 1'b0;
      if (load_data === 1'b1) load_cnt++;
      if (nCS !== 1'b0) ncs_low = 1'b0;
      if (dataout !== d) stable = 1'b0;
      if (inject && i == 1) start_pulse = 1'b1;
    end
    start_pulse = 1'b0;
    spi_busy    = 1'b1;
    for (int j = 0; j < len; j++) begin
      tick();
      start_pulse = 1'b0;
      if (load_data === 1'b1) load_cnt++;
      if (nCS !== 1'b0) ncs_low = 1'b0;
      if (dataout !== d) stable = 1'b0;
      if (inject && j == 0 && len >= 2) start_pulse = 1'b1;
    end
    start_pulse = 1'b0;
    spi_busy    = 1'b0;
    tick();
    ncs_after = nCS;
    if (load_data === 1'b1) load_cnt++;
    if (dataout !== d) stable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (nCS !== ncs_after) tail_ok = 1'b0;
      if (load_data === 1'b1) load_cnt++;
      if (dataout !== d) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_pulse = 1'b0; spi_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (nCS !== 1'b1 || load_data !== 1'b0 || dataout !== 8'h00) begin
        errors++;
        $display("FAIL reset cycle %0d: nCS=%b load=%b dataout=%h, want 1 0 00", i, nCS, load_data, dataout);
      end
    end
    rst = 1'b0;
    m_step = 0;
    m_page = 0;
    tick();
  endtask

  task automatic test_first_byte();
    logic [7:0] eb, d; logic ecs, ca; int lc; bit lf, st, nl, tl;
    model_next(eb, ecs);
    do_byte(50, 5, 1'b0, d, lc, lf, st, nl, ca, tl);
    checks++; if (!lf) begin errors++; $display("FAIL wren_load_timing: load_data not high cycle after start"); end
    checks++; if (lc !== 1) begin errors++; $display("FAIL wren_load_count: got %0d want 1", lc); end
    checks++; if (d !== eb) begin errors++; $display("FAIL wren_data: got %h want %h", d, eb); end
    checks++; if (!nl) begin errors++; $display("FAIL wren_ncs_low: nCS not low during byte"); end
    checks++; if (ca !== ecs) begin errors++; $display("FAIL wren_ncs_rise: got %b want %b", ca, ecs); end
    checks++; if (!tl) begin errors++; $display("FAIL wren_cs_gap: nCS did not stay high through gap"); end
    checks++; if (!st) begin errors++; $display("FAIL wren_stable: dataout changed before next start"); end
  endtask

  task automatic test_header();
    logic [7:0] eb, d; logic ecs, ca; int lc; bit lf, st, nl, tl;
    for (int n = 0; n < 3; n++) begin
      model_next(eb, ecs);
      do_byte(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0, d, lc, lf, st, nl, ca, tl);
      checks++; if (d !== eb) begin errors++; $display("FAIL header_data[%0d]: got %h want %h", n, d, eb); end
      checks++; if (!nl || ca !== ecs || !tl) begin errors++; $display("FAIL header_ncs[%0d]: low=%b after=%b want low=1 after=%b", n, nl, ca, ecs); end
      checks++; if (lc !== 1 || !lf) begin errors++; $display("FAIL header_load[%0d]: count=%0d first=%b want 1 1", n, lc, lf); end
    end
  endtask

  task automatic test_page_data();
    logic [7:0] eb, d; logic ecs, ca; int lc; bit lf, st, nl, tl;
    for (int n = 0; n < 256; n++) begin
      model_next(eb, ecs);
      do_byte(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 1'b0, d, lc, lf, st, nl, ca, tl);
      checks++; if (d !== eb) begin errors++; $display("FAIL data[%0d]: got %h want %h", n, d, eb); end
      checks++; if (ca !== ecs || !tl || !nl) begin errors++; $display("FAIL data_ncs[%0d]: low=%b after=%b want after=%b", n, nl, ca, ecs); end
      checks++; if (lc !== 1 || !st) begin errors++; $display("FAIL data_load[%0d]: count=%0d stable=%b want 1 1", n, lc, st); end
    end
  endtask

  task automatic test_second_page();
    logic [7:0] eb, d; logic ecs, ca; int lc; bit lf, st, nl, tl;
    for (int n = 0; n < 4; n++) begin
      model_next(eb, ecs);
      do_byte(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 1'b0, d, lc, lf, st, nl, ca, tl);
      checks++; if (d !== eb || ca !== ecs) begin errors++; $display("FAIL page2[%0d]: got %h/%b want %h/%b", n, d, ca, eb, ecs); end
      if (n == 2) begin
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL page2_addr_hi: got %h want 01", d); end
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] eb, d; logic ecs, ca; int lc; bit lf, st, nl, tl;
    model_next(eb, ecs);
    do_byte(4, 3, 1'b1, d, lc, lf, st, nl, ca, tl);
    checks++; if (lc !== 1) begin errors++; $display("FAIL ignored_start_load: count=%0d want 1", lc); end
    checks++; if (d !== eb || !st) begin errors++; $display("FAIL ignored_start_data: got %h stable=%b want %h", d, st, eb); end
    model_next(eb, ecs);
    do_byte(2, 2, 1'b0, d, lc, lf, st, nl, ca, tl);
    checks++; if (d !== eb) begin errors++; $display("FAIL ignored_start_step: got %h want %h", d, eb); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] eb, d; logic ecs, ca; int lc; bit lf, st, nl, tl;
    start_pulse = 1'b1; tick(); start_pulse = 1'b0;
    tick();
    spi_busy = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    checks++;
    if (nCS !== 1'b1 || load_data !== 1'b0 || dataout !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: nCS=%b load=%b dataout=%h want 1 0 00", nCS, load_data, dataout);
    end
    rst = 1'b0; spi_busy = 1'b0;
    m_step = 0;
    m_page = 0;
    tick();
    for (int n = 0; n < 4; n++) begin
      model_next(eb, ecs);
      do_byte(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 1'b0, d, lc, lf, st, nl, ca, tl);
      checks++; if (d !== eb || ca !== ecs) begin errors++; $display("FAIL after_reset[%0d]: got %h/%b want %h/%b", n, d, ca, eb, ecs); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_pulse = 1'b0;
    spi_busy = 1'b0;
    test_reset();
    test_first_byte();
    test_header();
    test_page_data();
    test_second_page();
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
